// File: rtl/egress_pkg.sv
// egress_pkg: shared types and constants for the egress frame reader (descriptor, FIFO word, FSM states)
package egress_pkg;
  localparam int WORD_BYTES = 16;
  localparam int DESC_ADDR_BITS = 18;
  localparam int DESC_LEN_BITS = 11;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} egress_state_t;
  typedef struct packed {
    logic [DESC_ADDR_BITS-1:0] addr;
    logic [DESC_LEN_BITS-1:0]  len;
  } egress_desc_t;
  typedef struct packed {
    logic [8*WORD_BYTES-1:0] data;
    logic [4:0]              bytes;
    logic                    last;
  } egress_word_t;
  function automatic logic [4:0] last_bytes(input logic [3:0] len_lsb);
    return len_lsb == 4'd0 ? 5'(WORD_BYTES) : {1'b0, len_lsb};
  endfunction
endpackage

// File: rtl/egress_skid_fifo.sv
// egress_skid_fifo: FWFT FIFO of egress_word_t; ports clk/rst, push/push_word, pop, head/valid, count (occupancy)
module egress_skid_fifo
  import egress_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  egress_word_t           push_word,
  input  logic                   pop,
  output egress_word_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  egress_word_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok;
  assign valid = count != '0;
  assign pop_ok = pop && valid;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end
  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && !pop_ok && count == CW'(DEPTH)));
endmodule

// File: rtl/egress_frame_reader.sv
// egress_frame_reader: fetches one stored frame per descriptor from QDR and streams it as 128-bit words.
// Ports: desc_* descriptor handshake, ram_rd_* controller read port, frame_* output stream, done_* freed range.
module egress_frame_reader
  import egress_pkg::*;
#(
  parameter int ADDR_BITS  = 18,
  parameter int LEN_BITS   = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [ADDR_BITS-1:0] desc_addr,
  input  logic [LEN_BITS-1:0]  desc_len,
  output logic                 ram_rd_en,
  output logic [ADDR_BITS-1:0] ram_rd_addr,
  input  logic                 ram_rd_valid,
  input  logic [143:0]         ram_rd_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 frame_last,
  output logic [4:0]           frame_bytes,
  output logic [127:0]         frame_data,
  output logic                 done_valid,
  output logic [ADDR_BITS-1:0] done_addr,
  output logic [LEN_BITS-4:0]  done_words
);
  localparam int WW = LEN_BITS - 3;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  egress_state_t state, state_n;
  logic [ADDR_BITS-1:0] addr_q;
  logic [4:0] tail_bytes_q;
  logic [WW-1:0] nwords_q, issue_cnt, recv_cnt, desc_nwords;
  logic [CW-1:0] outstanding, occupancy;
  logic desc_fire, issue, push, pop, recv_last, fifo_valid, unused_hi;
  egress_word_t push_word, head;
  assign desc_nwords = WW'(({1'b0, desc_len} + (LEN_BITS+1)'(WORD_BYTES - 1)) >> 4);
  assign desc_ready = state == IDLE;
  assign desc_fire = desc_valid && desc_ready;
  // credit: every issued read must already own a FIFO slot so backpressure can never drop RAM data
  assign issue = state == READ && issue_cnt != nwords_q &&
                 ({1'b0, outstanding} + {1'b0, occupancy}) < (CW+1)'(FIFO_DEPTH);
  assign ram_rd_en = issue;
  assign ram_rd_addr = issue ? addr_q + ADDR_BITS'(issue_cnt) : '0;
  // returns with nothing outstanding are stale leftovers from before a reset
  assign push = ram_rd_valid && outstanding != '0;
  assign recv_last = recv_cnt == nwords_q - WW'(1);
  assign push_word = '{data: ram_rd_data[127:0], bytes: recv_last ? tail_bytes_q : 5'(WORD_BYTES), last: recv_last};
  assign unused_hi = ^ram_rd_data[143:128];
  assign frame_valid = fifo_valid;
  assign frame_data = fifo_valid ? head.data : '0;
  assign frame_bytes = fifo_valid ? head.bytes : '0;
  assign frame_last = fifo_valid && head.last;
  assign pop = frame_valid && frame_ready;
  assign done_valid = state == DONE;
  assign done_addr = done_valid ? addr_q : '0;
  assign done_words = done_valid ? nwords_q : '0;
  egress_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .count     (occupancy)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (desc_fire) state_n = desc_len == '0 ? DONE : READ;
      READ:    if (issue && issue_cnt + WW'(1) == nwords_q) state_n = DRAIN;
      DRAIN:   if (pop && frame_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      tail_bytes_q <= '0;
      nwords_q     <= '0;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      outstanding  <= '0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding + CW'(issue) - CW'(push);
      if (desc_fire) begin
        addr_q       <= desc_addr;
        tail_bytes_q <= last_bytes(desc_len[3:0]);
        nwords_q     <= desc_nwords;
        issue_cnt    <= '0;
        recv_cnt     <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + WW'(1);
        if (push) recv_cnt <= recv_cnt + WW'(1);
      end
    end
  end
endmodule

// File: tb/tb_egress_frame_reader.sv
// tb_egress_frame_reader: scoreboard bench with a fixed-latency QDR read model and frame_ready patterns
module tb_egress_frame_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic desc_valid = 1'b0;
  logic desc_ready;
  logic [17:0] desc_addr = '0;
  logic [10:0] desc_len = '0;
  logic ram_rd_en;
  logic [17:0] ram_rd_addr;
  logic ram_rd_valid = 1'b0;
  logic [143:0] ram_rd_data = '0;
  logic frame_valid;
  logic frame_ready = 1'b1;
  logic frame_last;
  logic [4:0] frame_bytes;
  logic [127:0] frame_data;
  logic done_valid;
  logic [17:0] done_addr;
  logic [7:0] done_words;

  always #5 clk = ~clk;

  egress_frame_reader dut (
    .clk          (clk),
    .rst          (rst),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_addr    (desc_addr),
    .desc_len     (desc_len),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_valid (ram_rd_valid),
    .ram_rd_data  (ram_rd_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_last   (frame_last),
    .frame_bytes  (frame_bytes),
    .frame_data   (frame_data),
    .done_valid   (done_valid),
    .done_addr    (done_addr),
    .done_words   (done_words)
  );

  typedef struct {
    int          due;
    logic [17:0] addr;
  } rd_t;

  int checks = 0, passes = 0;
  int cyc = 0, lat = 5, rdy_mode = 0, hs_cyc = 0;
  int rd_cnt, fv_cnt, done_cnt = 0, words_seen, last_cnt, returned, popped, max_inflight, inflight;
  int first_rd_cyc, first_fv_cyc, last_pop_cyc, done_cyc;
  logic [4:0] last_bytes_seen;
  logic [17:0] done_addr_seen;
  logic [7:0] done_words_seen;
  logic [133:0] got;
  rd_t pend[$];
  logic [17:0] exp_addr_q[$];
  logic [133:0] exp_word_q[$];

  function automatic logic [127:0] ram_word(input logic [17:0] a);
    logic [31:0] w;
    w = {14'h0, a};
    return {w, ~w, w * 32'h9E3779B1, w ^ 32'hC0DE5A5A};
  endfunction

  // QDR model and downstream ready pattern, driven on the falling edge
  always @(negedge clk) begin
    cyc++;
    frame_ready = rdy_mode == 0 || cyc % 3 == 0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      ram_rd_valid = 1'b1;
      ram_rd_data = {16'hBEEF, ram_word(pend[0].addr)};
      void'(pend.pop_front());
      returned++;
    end else begin
      ram_rd_valid = 1'b0;
      ram_rd_data = '0;
    end
    if (ram_rd_en) pend.push_back('{due: cyc + lat, addr: ram_rd_addr});
  end

  // scoreboard: read addresses and accepted words against what the tests pushed
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (ram_rd_en) begin
        rd_cnt++;
        if (rd_cnt == 1) first_rd_cyc = cyc;
        checks++;
        if (exp_addr_q.size() == 0) $display("FAIL rd_addr unexpected read got %h", ram_rd_addr);
        else if (ram_rd_addr !== exp_addr_q[0]) $display("FAIL rd_addr got %h exp %h", ram_rd_addr, exp_addr_q[0]);
        else passes++;
        if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
      end
      if (frame_valid) begin
        fv_cnt++;
        if (fv_cnt == 1) first_fv_cyc = cyc;
      end
      if (frame_valid && frame_ready) begin
        words_seen++;
        popped++;
        last_pop_cyc = cyc;
        if (frame_last) begin
          last_cnt++;
          last_bytes_seen = frame_bytes;
        end
        got = {frame_data, frame_bytes, frame_last};
        checks++;
        if (exp_word_q.size() == 0) $display("FAIL word unexpected got %h", got);
        else if (got !== exp_word_q[0]) $display("FAIL word got %h exp %h", got, exp_word_q[0]);
        else passes++;
        if (exp_word_q.size() != 0) void'(exp_word_q.pop_front());
      end
      if (done_valid) begin
        done_cnt++;
        done_addr_seen = done_addr;
        done_words_seen = done_words;
        done_cyc = cyc;
      end
      inflight = pend.size() + returned - popped;
      if (inflight > max_inflight) max_inflight = inflight;
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; fv_cnt = 0; words_seen = 0; last_cnt = 0; returned = 0; popped = 0; max_inflight = 0;
    first_rd_cyc = 0; first_fv_cyc = 0; last_pop_cyc = 0; last_bytes_seen = '0;
  endtask

  task automatic send_desc(input logic [17:0] a, input logic [10:0] len);
    int nw;
    logic [17:0] wa;
    logic [4:0] b;
    bit ok;
    nw = (len + 15) / 16;
    for (int i = 0; i < nw; i++) begin
      wa = a + 18'(i);
      b = (i != nw - 1 || len % 16 == 0) ? 5'd16 : 5'(len % 16);
      exp_addr_q.push_back(wa);
      exp_word_q.push_back({ram_word(wa), b, i == nw - 1});
    end
    @(negedge clk);
    desc_valid = 1'b1;
    desc_addr = a;
    desc_len = len;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      #1;
      ok = desc_ready;
      hs_cyc = cyc;
      @(negedge clk);
    end
    desc_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL desc_accept desc_ready stayed %b exp 1", desc_ready);
    end
  endtask

  task automatic wait_done(input int start_cnt, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == start_cnt) $display("FAIL %s done_timeout got no done pulse in %0d cycles exp 1", name, budget);
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if (desc_ready !== 1'b1) $display("FAIL reset_desc_ready got %b exp 1", desc_ready); else passes++;
    checks++;
    if ({ram_rd_en, ram_rd_addr} !== 19'h0) $display("FAIL reset_rd got %b/%h exp 0/0", ram_rd_en, ram_rd_addr); else passes++;
    checks++;
    if ({frame_valid, frame_last, frame_bytes, frame_data} !== 135'h0)
      $display("FAIL reset_frame got %b %b %h %h exp zeros", frame_valid, frame_last, frame_bytes, frame_data);
    else passes++;
    checks++;
    if ({done_valid, done_addr, done_words} !== 27'h0)
      $display("FAIL reset_done got %b %h %h exp zeros", done_valid, done_addr, done_words);
    else passes++;
  endtask

  task automatic test_basic();
    int d0;
    lat = 5; rdy_mode = 0;
    clear_stats();
    d0 = done_cnt;
    send_desc(18'h100, 11'd64);
    wait_done(d0, 200, "basic");
    checks++;
    if (done_addr_seen !== 18'h100 || done_words_seen !== 8'd4)
      $display("FAIL basic_done got %h/%0d exp 100/4", done_addr_seen, done_words_seen);
    else passes++;
    checks++;
    if (words_seen !== 4 || rd_cnt !== 4 || last_cnt !== 1)
      $display("FAIL basic_counts got words %0d reads %0d lasts %0d exp 4 4 1", words_seen, rd_cnt, last_cnt);
    else passes++;
    checks++;
    if (last_bytes_seen !== 5'd16) $display("FAIL basic_last_bytes got %0d exp 16", last_bytes_seen); else passes++;
    checks++;
    if (first_rd_cyc !== hs_cyc + 1) $display("FAIL basic_rd_latency got %0d exp %0d", first_rd_cyc, hs_cyc + 1); else passes++;
    checks++;
    if (first_fv_cyc !== first_rd_cyc + lat + 1)
      $display("FAIL basic_fv_latency got %0d exp %0d", first_fv_cyc, first_rd_cyc + lat + 1);
    else passes++;
    checks++;
    if (last_pop_cyc - first_fv_cyc !== 3) $display("FAIL basic_throughput got %0d exp 3", last_pop_cyc - first_fv_cyc); else passes++;
    checks++;
    if (desc_ready !== 1'b1) $display("FAIL basic_ready_after_done got %b exp 1", desc_ready); else passes++;
  endtask

  task automatic test_len65();
    int d0;
    clear_stats();
    d0 = done_cnt;
    send_desc(18'h200, 11'd65);
    wait_done(d0, 200, "len65");
    checks++;
    if (rd_cnt !== 5 || words_seen !== 5 || last_cnt !== 1)
      $display("FAIL len65_counts got reads %0d words %0d lasts %0d exp 5 5 1", rd_cnt, words_seen, last_cnt);
    else passes++;
    checks++;
    if (last_bytes_seen !== 5'd1 || done_words_seen !== 8'd5)
      $display("FAIL len65_tail got bytes %0d words %0d exp 1 5", last_bytes_seen, done_words_seen);
    else passes++;
  endtask

  task automatic test_wrap();
    int d0;
    clear_stats();
    d0 = done_cnt;
    send_desc(18'h3FFFE, 11'd48);
    wait_done(d0, 200, "wrap");
    checks++;
    if (done_addr_seen !== 18'h3FFFE || done_words_seen !== 8'd3 || rd_cnt !== 3)
      $display("FAIL wrap_done got %h/%0d reads %0d exp 3fffe/3 3", done_addr_seen, done_words_seen, rd_cnt);
    else passes++;
  endtask

  task automatic test_backpressure();
    int d0;
    lat = 8; rdy_mode = 1;
    clear_stats();
    d0 = done_cnt;
    send_desc(18'h1000, 11'd1500);
    wait_done(d0, 2000, "backpressure");
    repeat (20) @(negedge clk);
    checks++;
    if (words_seen !== 94 || exp_word_q.size() !== 0)
      $display("FAIL bp_words got %0d left %0d exp 94 0", words_seen, exp_word_q.size());
    else passes++;
    checks++;
    if (max_inflight > 16) $display("FAIL bp_credit got %0d exp <=16", max_inflight); else passes++;
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL bp_done_pulses got %0d exp 1", done_cnt - d0); else passes++;
    rdy_mode = 0;
  endtask

  task automatic test_len0();
    int d0;
    lat = 5;
    clear_stats();
    d0 = done_cnt;
    send_desc(18'h55, 11'd0);
    wait_done(d0, 10, "len0");
    checks++;
    if (done_words_seen !== 8'd0 || done_addr_seen !== 18'h55)
      $display("FAIL len0_done got %h/%0d exp 55/0", done_addr_seen, done_words_seen);
    else passes++;
    checks++;
    if (done_cyc - hs_cyc > 2) $display("FAIL len0_latency got %0d exp <=2", done_cyc - hs_cyc); else passes++;
    checks++;
    if (rd_cnt !== 0 || fv_cnt !== 0) $display("FAIL len0_activity got reads %0d valids %0d exp 0 0", rd_cnt, fv_cnt); else passes++;
  endtask

  task automatic test_reset_mid();
    int d0, n;
    lat = 8; rdy_mode = 0;
    clear_stats();
    d0 = done_cnt;
    send_desc(18'h8000, 11'd1500);
    n = 0;
    while (words_seen < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (words_seen < 10) $display("FAIL mid_progress got %0d words exp 10", words_seen); else passes++;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    exp_addr_q.delete();
    exp_word_q.delete();
    checks++;
    if ({frame_valid, frame_data, ram_rd_en, done_valid} !== 131'h0 || desc_ready !== 1'b1)
      $display("FAIL mid_reset_outputs got fv %b rd %b done %b ready %b exp 0 0 0 1", frame_valid, ram_rd_en, done_valid, desc_ready);
    else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt !== d0) $display("FAIL mid_no_done got %0d pulses exp 0", done_cnt - d0); else passes++;
    clear_stats();
    send_desc(18'h2345, 11'd16);
    wait_done(d0, 200, "mid_next");
    checks++;
    if (words_seen !== 1 || done_words_seen !== 8'd1 || last_bytes_seen !== 5'd16 || exp_word_q.size() !== 0)
      $display("FAIL mid_next got words %0d done_words %0d bytes %0d exp 1 1 16", words_seen, done_words_seen, last_bytes_seen);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_basic();
    test_len65();
    test_wrap();
    test_backpressure();
    test_len0();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
